// File: rtl/pipeline_pkg.sv
// Shared stage indices and helpers for the 5-stage core pipeline control.
package pipeline_pkg;

   localparam int STG_FETCH  = 0;
   localparam int STG_DECODE = 1;
   localparam int STG_ALU    = 2;
   localparam int STG_MEM    = 3;
   localparam int STG_WB     = 4;
   localparam int NUM_STAGES = 5;

   typedef logic [NUM_STAGES-1:0] stage_vec_t;

   // Bits needed to hold a stage index; never narrower than one bit.
   function automatic int idxWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pipe_prio_enc.sv
// Highest-set-bit finder: returns whether any request is set and the
// index of the oldest (highest-numbered) requesting stage.
module pipe_prio_enc #(
   parameter int W  = 5,
   parameter int IW = 3
) (
   input  logic [W-1:0]  i_req,
   output logic          o_found,
   output logic [IW-1:0] o_idx
);

   // Scanning upward lets the last hit, i.e. the highest index, win.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = 0; i < W; i++) begin
         if (i_req[i]) begin
            o_found = 1'b1;
            o_idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: arbitrates per-stage stall/flush requests,
// drives stage enables and valid bits, and tracks stall/flush statistics.
module pipeline_sequencer #(
   parameter int NUM_STAGES = pipeline_pkg::NUM_STAGES,
   parameter int FLUSH_LAT  = 2,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_valid,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic [NUM_STAGES-1:0] flush_req,
   output logic [NUM_STAGES-1:0] clk_en,
   output logic [NUM_STAGES-1:0] valid,
   output logic [NUM_STAGES-1:0] flush_out,
   output logic                  fetch_ready,
   output logic                  idle,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   import pipeline_pkg::*;

   localparam int IW  = idxWidth(NUM_STAGES);
   localparam int RCW = (FLUSH_LAT < 1) ? 1 : $clog2(FLUSH_LAT + 1);
   localparam logic [RCW-1:0] RC_LOAD = RCW'(FLUSH_LAT);

   logic                  w_sFound;
   logic [IW-1:0]         w_sIdx;
   logic                  w_fFound;
   logic [IW-1:0]         w_fIdx;
   logic                  w_flushHon;
   logic                  w_stallHon;
   logic [NUM_STAGES-1:0] w_shifted;
   logic [NUM_STAGES-1:0] w_validNext;
   logic [RCW-1:0]        w_recNext;

   logic [NUM_STAGES-1:0] r_valid;
   logic [RCW-1:0]        r_recCnt;
   logic                  r_idle;
   logic [CNT_W-1:0]      r_stallCycles;
   logic [CNT_W-1:0]      r_flushCount;

   pipe_prio_enc #(.W(NUM_STAGES), .IW(IW)) u_stallEnc (
      .i_req   (stall_req),
      .o_found (w_sFound),
      .o_idx   (w_sIdx)
   );

   pipe_prio_enc #(.W(NUM_STAGES), .IW(IW)) u_flushEnc (
      .i_req   (flush_req),
      .o_found (w_fFound),
      .o_idx   (w_fIdx)
   );

   // The older request wins; a tie on the same stage goes to the stall.
   assign w_flushHon = w_fFound & (~w_sFound | (w_fIdx > w_sIdx));
   assign w_stallHon = w_sFound & ~w_flushHon;

   always_comb begin
      clk_en    = '1;
      flush_out = '0;
      for (int j = 0; j < NUM_STAGES; j++) begin
         if (w_stallHon && (IW'(j) <= w_sIdx)) clk_en[j] = 1'b0;
         if (w_flushHon && (IW'(j) < w_fIdx))  flush_out[j] = 1'b1;
      end
   end

   assign fetch_ready = (r_recCnt == '0) & clk_en[STG_FETCH] & ~w_flushHon;
   assign w_shifted   = {r_valid[NUM_STAGES-2:0], fetch_valid & fetch_ready};

   // Stalled stages hold, the stage just past the stall takes a bubble.
   always_comb begin
      w_validNext = w_shifted;
      for (int j = 0; j < NUM_STAGES; j++) begin
         if (w_flushHon) begin
            if (IW'(j) <= w_fIdx) w_validNext[j] = 1'b0;
         end else if (w_stallHon) begin
            if (IW'(j) <= w_sIdx)                   w_validNext[j] = r_valid[j];
            else if (IW'(j) == w_sIdx + IW'(1))     w_validNext[j] = 1'b0;
         end
      end
   end

   assign w_recNext = w_flushHon        ? RC_LOAD :
                      (r_recCnt != '0)  ? r_recCnt - RCW'(1) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid       <= '0;
         r_recCnt      <= '0;
         r_idle        <= 1'b1;
         r_stallCycles <= '0;
         r_flushCount  <= '0;
      end else begin
         r_valid       <= w_validNext;
         r_recCnt      <= w_recNext;
         r_idle        <= (w_validNext == '0) && (w_recNext == '0);
         r_stallCycles <= r_stallCycles + CNT_W'(w_stallHon);
         r_flushCount  <= r_flushCount + CNT_W'(w_flushHon);
      end
   end

   assign valid        = r_valid;
   assign idle         = r_idle;
   assign stall_cycles = r_stallCycles;
   assign flush_count  = r_flushCount;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run, all compared against a stage-array reference model.
module tb_pipeline_sequencer;

   localparam int N        = 5;
   localparam int FLUSH_LAT = 2;

   logic          clk;
   logic          rst;
   logic          fetch_valid;
   logic [N-1:0]  stall_req;
   logic [N-1:0]  flush_req;
   logic [N-1:0]  clk_en;
   logic [N-1:0]  valid;
   logic [N-1:0]  flush_out;
   logic          fetch_ready;
   logic          idle;
   logic [31:0]   stall_cycles;
   logic [31:0]   flush_count;

   int nVectors     = 0;
   int nMiscompares = 0;

   // Reference model state: one live flag per stage plus recovery and stats.
   int          mValid[N];
   int          mCnt;
   logic [31:0] mStalls;
   logic [31:0] mFlushes;
   logic        mIdle;
   int          ms, mf;
   bit          mFlushH, mStallH;
   logic [N-1:0] eClkEn, eFlushOut;
   logic         eReady;

   pipeline_sequencer #(.NUM_STAGES(N), .FLUSH_LAT(FLUSH_LAT), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_valid  (fetch_valid),
      .stall_req    (stall_req),
      .flush_req    (flush_req),
      .clk_en       (clk_en),
      .valid        (valid),
      .flush_out    (flush_out),
      .fetch_ready  (fetch_ready),
      .idle         (idle),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int highestSet(input logic [N-1:0] v);
      for (int k = N - 1; k >= 0; k--) if (v[k]) return k;
      return -1;
   endfunction

   function automatic logic [N-1:0] modelValid();
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) r[k] = (mValid[k] != 0);
      return r;
   endfunction

   // Drive inputs and work out the expected same-cycle outputs.
   task automatic applyStimulus(input logic fv, input logic rs,
                                input logic [N-1:0] st, input logic [N-1:0] fl);
      rst = rs; fetch_valid = fv; stall_req = st; flush_req = fl;
      ms = highestSet(st);
      mf = highestSet(fl);
      mFlushH = (mf >= 0) && ((ms < 0) || (mf > ms));
      mStallH = (ms >= 0) && !mFlushH;
      for (int j = 0; j < N; j++) begin
         eClkEn[j]    = !(mStallH && (j <= ms));
         eFlushOut[j] = mFlushH && (j < mf);
      end
      eReady = (mCnt == 0) && eClkEn[0] && !mFlushH;
      #1;
   endtask

   // Clock edge: move the model one cycle forward, then let the DUT settle.
   task automatic advance();
      int nv[N];
      @(posedge clk);
      if (rst) begin
         for (int j = 0; j < N; j++) nv[j] = 0;
         mCnt = 0; mStalls = 0; mFlushes = 0;
      end else begin
         for (int j = 0; j < N; j++) begin
            if (mFlushH)                 nv[j] = (j <= mf) ? 0 : mValid[j-1];
            else if (mStallH && j <= ms) nv[j] = mValid[j];
            else if (mStallH && j == ms + 1) nv[j] = 0;
            else if (j == 0)             nv[j] = (fetch_valid && eReady) ? 1 : 0;
            else                         nv[j] = mValid[j-1];
         end
         mCnt = mFlushH ? FLUSH_LAT : ((mCnt > 0) ? mCnt - 1 : 0);
         if (mStallH) mStalls  = mStalls + 32'd1;
         if (mFlushH) mFlushes = mFlushes + 32'd1;
      end
      mIdle = (mCnt == 0);
      for (int j = 0; j < N; j++) begin
         mValid[j] = nv[j];
         if (nv[j] != 0) mIdle = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(0, 1, '0, '0); advance();
      applyStimulus(0, 1, '0, '0); advance();
      applyStimulus(0, 0, '0, '0);
      nVectors++; if (valid !== 5'b00000) begin nMiscompares++; $display("[TB] FAIL reset_valid: got %b, exp %b", valid, 5'b00000); end
      nVectors++; if (clk_en !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL reset_clk_en: got %b, exp %b", clk_en, 5'b11111); end
      nVectors++; if (fetch_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_fetch_ready: got %b, exp 1", fetch_ready); end
      nVectors++; if (idle !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_idle: got %b, exp 1", idle); end
      nVectors++; if (stall_cycles !== 32'd0) begin nMiscompares++; $display("[TB] FAIL reset_stall_cycles: got %0d, exp 0", stall_cycles); end
      nVectors++; if (flush_count !== 32'd0) begin nMiscompares++; $display("[TB] FAIL reset_flush_count: got %0d, exp 0", flush_count); end
   endtask

   task automatic test_fill();
      logic [N-1:0] fillExp[N] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
      for (int i = 0; i < N; i++) begin
         applyStimulus(1, 0, '0, '0);
         nVectors++; if (fetch_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL fill_ready[%0d]: got %b, exp 1", i, fetch_ready); end
         advance();
         nVectors++; if (valid !== fillExp[i]) begin nMiscompares++; $display("[TB] FAIL fill_valid[%0d]: got %b, exp %b", i, valid, fillExp[i]); end
         nVectors++; if (idle !== 1'b0) begin nMiscompares++; $display("[TB] FAIL fill_idle[%0d]: got %b, exp 0", i, idle); end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 5'b01000, '0);
         nVectors++; if (clk_en !== 5'b10000) begin nMiscompares++; $display("[TB] FAIL stall_clk_en[%0d]: got %b, exp %b", i, clk_en, 5'b10000); end
         nVectors++; if (fetch_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL stall_ready[%0d]: got %b, exp 0", i, fetch_ready); end
         advance();
         nVectors++; if (valid !== 5'b01111) begin nMiscompares++; $display("[TB] FAIL stall_valid[%0d]: got %b, exp %b", i, valid, 5'b01111); end
      end
      nVectors++; if (stall_cycles !== 32'd2) begin nMiscompares++; $display("[TB] FAIL stall_cycles: got %0d, exp 2", stall_cycles); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < N; i++) begin applyStimulus(1, 0, '0, '0); advance(); end
      applyStimulus(1, 0, '0, 5'b10000);
      nVectors++; if (flush_out !== 5'b01111) begin nMiscompares++; $display("[TB] FAIL flush_out: got %b, exp %b", flush_out, 5'b01111); end
      nVectors++; if (clk_en !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL flush_clk_en: got %b, exp %b", clk_en, 5'b11111); end
      nVectors++; if (fetch_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL flush_ready: got %b, exp 0", fetch_ready); end
      advance();
      nVectors++; if (valid !== 5'b00000) begin nMiscompares++; $display("[TB] FAIL flush_valid: got %b, exp %b", valid, 5'b00000); end
      nVectors++; if (flush_count !== 32'd1) begin nMiscompares++; $display("[TB] FAIL flush_count: got %0d, exp 1", flush_count); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, '0, '0);
         nVectors++; if (fetch_ready !== eReady) begin nMiscompares++; $display("[TB] FAIL recov_ready[%0d]: got %b, exp %b", i, fetch_ready, eReady); end
         advance();
         nVectors++; if (valid !== modelValid()) begin nMiscompares++; $display("[TB] FAIL recov_valid[%0d]: got %b, exp %b", i, valid, modelValid()); end
      end
   endtask

   task automatic test_conflicts();
      applyStimulus(1, 0, 5'b00010, 5'b10000);
      nVectors++; if (flush_out !== 5'b01111) begin nMiscompares++; $display("[TB] FAIL conf1_flush_out: got %b, exp %b", flush_out, 5'b01111); end
      nVectors++; if (clk_en !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL conf1_clk_en: got %b, exp %b", clk_en, 5'b11111); end
      advance();
      nVectors++; if (stall_cycles !== mStalls) begin nMiscompares++; $display("[TB] FAIL conf1_stall_cycles: got %0d, exp %0d", stall_cycles, mStalls); end
      nVectors++; if (flush_count !== mFlushes) begin nMiscompares++; $display("[TB] FAIL conf1_flush_count: got %0d, exp %0d", flush_count, mFlushes); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 5'b10000, 5'b00100);
         nVectors++; if (flush_out !== 5'b00000) begin nMiscompares++; $display("[TB] FAIL conf2_flush_out[%0d]: got %b, exp %b", i, flush_out, 5'b00000); end
         nVectors++; if (clk_en !== 5'b00000) begin nMiscompares++; $display("[TB] FAIL conf2_clk_en[%0d]: got %b, exp %b", i, clk_en, 5'b00000); end
         advance();
      end
      applyStimulus(1, 0, '0, 5'b00100);
      nVectors++; if (flush_out !== 5'b00011) begin nMiscompares++; $display("[TB] FAIL conf2_release: got %b, exp %b", flush_out, 5'b00011); end
      advance();
      nVectors++; if (flush_count !== mFlushes) begin nMiscompares++; $display("[TB] FAIL conf2_flush_count: got %0d, exp %0d", flush_count, mFlushes); end
      nVectors++; if (valid !== modelValid()) begin nMiscompares++; $display("[TB] FAIL conf2_valid: got %b, exp %b", valid, modelValid()); end
   endtask

   task automatic test_reset_mid_recovery();
      applyStimulus(1, 0, '0, 5'b00001); advance();
      applyStimulus(1, 1, 5'b00100, 5'b00010); advance();
      applyStimulus(0, 0, '0, '0);
      nVectors++; if (fetch_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rmid_ready: got %b, exp 1", fetch_ready); end
      nVectors++; if (flush_count !== 32'd0) begin nMiscompares++; $display("[TB] FAIL rmid_flush_count: got %0d, exp 0", flush_count); end
      nVectors++; if (stall_cycles !== 32'd0) begin nMiscompares++; $display("[TB] FAIL rmid_stall_cycles: got %0d, exp 0", stall_cycles); end
      nVectors++; if (idle !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rmid_idle: got %b, exp 1", idle); end
      nVectors++; if (valid !== 5'b00000) begin nMiscompares++; $display("[TB] FAIL rmid_valid: got %b, exp %b", valid, 5'b00000); end
   endtask

   task automatic test_random();
      logic [N-1:0] st, fl;
      for (int i = 0; i < 400; i++) begin
         st = 5'($urandom) & 5'($urandom) & 5'($urandom);
         fl = 5'($urandom) & 5'($urandom) & 5'($urandom);
         applyStimulus(1'($urandom), ($urandom_range(0, 49) == 0), st, fl);
         nVectors++; if (clk_en !== eClkEn) begin nMiscompares++; $display("[TB] FAIL rnd_clk_en[%0d]: got %b, exp %b", i, clk_en, eClkEn); end
         nVectors++; if (flush_out !== eFlushOut) begin nMiscompares++; $display("[TB] FAIL rnd_flush_out[%0d]: got %b, exp %b", i, flush_out, eFlushOut); end
         nVectors++; if (fetch_ready !== eReady) begin nMiscompares++; $display("[TB] FAIL rnd_ready[%0d]: got %b, exp %b", i, fetch_ready, eReady); end
         advance();
         nVectors++; if (valid !== modelValid()) begin nMiscompares++; $display("[TB] FAIL rnd_valid[%0d]: got %b, exp %b", i, valid, modelValid()); end
         nVectors++; if (idle !== mIdle) begin nMiscompares++; $display("[TB] FAIL rnd_idle[%0d]: got %b, exp %b", i, idle, mIdle); end
         nVectors++; if (stall_cycles !== mStalls) begin nMiscompares++; $display("[TB] FAIL rnd_stall_cycles[%0d]: got %0d, exp %0d", i, stall_cycles, mStalls); end
         nVectors++; if (flush_count !== mFlushes) begin nMiscompares++; $display("[TB] FAIL rnd_flush_count[%0d]: got %0d, exp %0d", i, flush_count, mFlushes); end
      end
   endtask

   initial begin
      for (int j = 0; j < N; j++) mValid[j] = 0;
      mCnt = 0; mStalls = 0; mFlushes = 0; mIdle = 1'b1;
      test_reset();
      test_fill();
      test_stall();
      test_flush();
      test_conflicts();
      test_reset_mid_recovery();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
